// File: rtl/pn_drive_bldc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pn_drive_bldc : six-step BLDC gate driver with integrated PWM chopper
// Rev 1.0
// ----------------------------------------------------------------------------
module pn_drive_bldc #(
   parameter int PWM_WIDTH = 8,
   parameter int DEAD_TIME = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pwm_en,
   input  logic [PWM_WIDTH-1:0] pwm_in,
   input  logic                 H1,
   input  logic                 H2,
   input  logic                 H3,
   output logic                 pwm_out,
   output logic                 AP,
   output logic                 AN,
   output logic                 BP,
   output logic                 BN,
   output logic                 CP,
   output logic                 CN
);

   localparam int                   DT_W    = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
   localparam logic [DT_W-1:0]      DT_LOAD = DT_W'(DEAD_TIME - 1);
   localparam logic [PWM_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_DEAD = 1'b1
   } state_t;

   logic [PWM_WIDTH-1:0] cnt_q, cnt_d;
   logic [PWM_WIDTH-1:0] duty_q, duty_d;
   logic                 pwm_q, pwm_d;
   logic [2:0]           hall_m_q, hall_m_d;
   logic [2:0]           hall_s_q, hall_s_d;
   // Gate patterns are {hi[C,B,A], lo[C,B,A]}
   logic [5:0]           pat_q, pat_d;
   logic [5:0]           tgt_q, tgt_d;
   logic [5:0]           pat_dec;
   logic [DT_W-1:0]      dt_q, dt_d;
   state_t               state_q, state_d;

   always_comb begin
      cnt_d    = cnt_q + 1'b1;
      duty_d   = (cnt_q == CNT_MAX) ? pwm_in : duty_q;
      pwm_d    = pwm_en & (cnt_q < duty_q);
      hall_m_d = {H1, H2, H3};
      hall_s_d = hall_m_q;
   end

   always_comb begin
      pat_dec = 6'b000_000;
      case (hall_s_q)
         3'b101:  pat_dec = 6'b001_010;
         3'b100:  pat_dec = 6'b001_100;
         3'b110:  pat_dec = 6'b010_100;
         3'b010:  pat_dec = 6'b010_001;
         3'b011:  pat_dec = 6'b100_001;
         3'b001:  pat_dec = 6'b100_010;
         default: pat_dec = 6'b000_000;
      endcase
   end

   // Any change of the decoded pattern drops every gate, then waits DEAD_TIME
   // clocks; a further change while waiting restarts the wait on the new target.
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      tgt_d   = tgt_q;
      dt_d    = dt_q;
      case (state_q)
         ST_RUN: begin
            if (pat_dec != pat_q) begin
               state_d = ST_DEAD;
               pat_d   = 6'b000_000;
               tgt_d   = pat_dec;
               dt_d    = DT_LOAD;
            end
         end
         ST_DEAD: begin
            if (pat_dec != tgt_q) begin
               tgt_d = pat_dec;
               dt_d  = DT_LOAD;
            end else if (dt_q == '0) begin
               state_d = ST_RUN;
               pat_d   = tgt_q;
            end else begin
               dt_d = dt_q - 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         duty_q   <= '0;
         pwm_q    <= 1'b0;
         hall_m_q <= 3'b000;
         hall_s_q <= 3'b000;
         pat_q    <= 6'b000_000;
         tgt_q    <= 6'b000_000;
         dt_q     <= '0;
         state_q  <= ST_RUN;
      end else begin
         cnt_q    <= cnt_d;
         duty_q   <= duty_d;
         pwm_q    <= pwm_d;
         hall_m_q <= hall_m_d;
         hall_s_q <= hall_s_d;
         pat_q    <= pat_d;
         tgt_q    <= tgt_d;
         dt_q     <= dt_d;
         state_q  <= state_d;
      end
   end

   // pwm_en gates the outputs directly so disabling never waits for a clock
   assign pwm_out = pwm_q;
   assign AP      = pat_q[3] & pwm_q & pwm_en;
   assign BP      = pat_q[4] & pwm_q & pwm_en;
   assign CP      = pat_q[5] & pwm_q & pwm_en;
   assign AN      = pat_q[0] & pwm_en;
   assign BN      = pat_q[1] & pwm_en;
   assign CN      = pat_q[2] & pwm_en;

endmodule
`default_nettype wire

// File: tb/tb_pn_drive_bldc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pn_drive_bldc : scoreboard bench for the six-step gate driver
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pn_drive_bldc;

   localparam int PWM_WIDTH = 8;
   localparam int DEAD_TIME = 4;
   localparam int PERIOD    = 256;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       pwm_en = 1'b0;
   logic [7:0] pwm_in = 8'h00;
   logic       H1 = 1'b0, H2 = 1'b0, H3 = 1'b0;
   logic       pwm_out, AP, AN, BP, BN, CP, CN;

   always #5 clk = ~clk;

   pn_drive_bldc #(.PWM_WIDTH(PWM_WIDTH), .DEAD_TIME(DEAD_TIME)) dut (
      .clk(clk), .rst_n(rst_n), .pwm_en(pwm_en), .pwm_in(pwm_in),
      .H1(H1), .H2(H2), .H3(H3),
      .pwm_out(pwm_out), .AP(AP), .AN(AN), .BP(BP), .BN(BN), .CP(CP), .CN(CN)
   );

   typedef struct packed {
      logic [2:0] hi;   // {C,B,A} high side
      logic [2:0] lo;   // {C,B,A} low side
   } pat_t;

   pat_t       gq[$];
   int         dq[$];
   int         tests = 0;
   int         fails = 0;
   int         ecount;
   logic [2:0] cur_h = 3'b000;

   // Clocks since reset release; modulo PERIOD this is the PWM phase
   always @(posedge clk or negedge rst_n)
      if (!rst_n) ecount <= 0;
      else        ecount <= ecount + 1;

   function automatic pat_t hall_table(input logic [2:0] h);
      pat_t r;
      r = '0;
      case (h)
         3'b101: begin r.hi = 3'b001; r.lo = 3'b010; end
         3'b100: begin r.hi = 3'b001; r.lo = 3'b100; end
         3'b110: begin r.hi = 3'b010; r.lo = 3'b100; end
         3'b010: begin r.hi = 3'b010; r.lo = 3'b001; end
         3'b011: begin r.hi = 3'b100; r.lo = 3'b001; end
         3'b001: begin r.hi = 3'b100; r.lo = 3'b010; end
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Shoot-through and per-phase dead-time watch over the whole run
   int last_drv [3] = '{0, 0, 0};
   int off_run  [3] = '{0, 0, 0};
   always @(negedge clk) begin
      logic [2:0] p, n;
      int cur;
      p = {CP, BP, AP};
      n = {CN, BN, AN};
      tests++;
      if ((p & n) != 3'b000 || $countones(p) > 1 || $countones(n) > 1) begin
         fails++;
         $display("FAIL shoot_through t=%0t: P=%b N=%b, required disjoint one-hot", $time, p, n);
      end
      for (int i = 0; i < 3; i++) begin
         cur = p[i] ? 1 : (n[i] ? 2 : 0);
         if (cur == 0) begin
            off_run[i]++;
         end else begin
            if (last_drv[i] != 0 && cur != last_drv[i]) begin
               tests++;
               if (off_run[i] < DEAD_TIME) begin
                  fails++;
                  $display("FAIL dead_time phase %0d t=%0t: off %0d clocks, required >= %0d",
                           i, $time, off_run[i], DEAD_TIME);
               end
            end
            last_drv[i] = cur;
            off_run[i]  = 0;
         end
      end
   end

   task automatic wait_period_start(input string nm);
      int n = 0;
      while ((ecount % PERIOD) != 0 && n < 2 * PERIOD) begin
         tick;
         n++;
      end
      if ((ecount % PERIOD) != 0) begin
         tests++;
         fails++;
         $display("FAIL %s_align: phase %0d, required 0", nm, ecount % PERIOD);
      end
   endtask

   // One full PWM period: pops the required high count, checks the gates
   task automatic measure_period(input string nm, input pat_t g, input int chg_at,
                                 input logic [7:0] chg_val, output int first_low);
      int highs = 0;
      int bad = 0;
      int exp_h;
      first_low = -1;
      for (int k = 0; k < PERIOD; k++) begin
         if (k == chg_at) pwm_in = chg_val;
         tick;
         if (pwm_out === 1'b1) highs++;
         else if (first_low < 0) first_low = k;
         if ({CN, BN, AN} !== g.lo || {CP, BP, AP} !== (g.hi & {3{pwm_out}})) bad++;
      end
      exp_h = dq.pop_front();
      tests++;
      if (highs != exp_h) begin
         fails++;
         $display("FAIL %s_highs: got %0d, required %0d", nm, highs, exp_h);
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL %s_gates: %0d wrong cycles, required 0", nm, bad);
      end
   endtask

   task automatic check_post_reset(input string nm);
      pat_t e, g;
      int highs = 0;
      int exp_h;
      g = hall_table(cur_h);
      for (int j = 1; j <= DEAD_TIME + 4; j++) begin
         e = '0;
         if (j > DEAD_TIME + 2) e = g;
         gq.push_back(e);
      end
      dq.push_back(0);
      rst_n = 1'b1;
      for (int j = 1; j <= DEAD_TIME + 4; j++) begin
         tick;
         e = gq.pop_front();
         tests++;
         if ({CN, BN, AN} !== e.lo || {CP, BP, AP} !== (e.hi & {3{pwm_out}})) begin
            fails++;
            $display("FAIL %s_gates cycle %0d: P=%b N=%b, required P=%b N=%b",
                     nm, j, {CP, BP, AP}, {CN, BN, AN}, e.hi & {3{pwm_out}}, e.lo);
         end
      end
      for (int k = DEAD_TIME + 5; k <= PERIOD; k++) begin
         tick;
         if (pwm_out === 1'b1) highs++;
      end
      exp_h = dq.pop_front();
      tests++;
      if (highs != exp_h) begin
         fails++;
         $display("FAIL %s_first_period: pwm high %0d, required %0d", nm, highs, exp_h);
      end
   endtask

   task automatic hall_step(input logic [2:0] to_h, input int hold);
      pat_t old_p, new_p, e;
      int fl;
      old_p = hall_table(cur_h);
      new_p = hall_table(to_h);
      for (int j = 1; j <= DEAD_TIME + 6; j++) begin
         if (j <= 2)                  e = old_p;
         else if (j <= DEAD_TIME + 2) e = '0;
         else                         e = new_p;
         gq.push_back(e);
      end
      {H1, H2, H3} = to_h;
      for (int j = 1; j <= DEAD_TIME + 6; j++) begin
         tick;
         e = gq.pop_front();
         tests++;
         if ({CN, BN, AN} !== e.lo || {CP, BP, AP} !== (e.hi & {3{pwm_out}})) begin
            fails++;
            $display("FAIL hall_%b_to_%b cycle %0d: P=%b N=%b, required P=%b N=%b", cur_h, to_h,
                     j, {CP, BP, AP}, {CN, BN, AN}, e.hi & {3{pwm_out}}, e.lo);
         end
      end
      cur_h = to_h;
      dq.push_back(124);
      measure_period($sformatf("hall_%b", to_h), new_p, -1, 8'h00, fl);
      repeat (hold - (DEAD_TIME + 6) - PERIOD) tick;
   endtask

   task automatic test_reset;
      #2;
      rst_n  = 1'b0;
      pwm_en = 1'b1;
      pwm_in = 8'h7C;
      {H1, H2, H3} = 3'b101;
      cur_h  = 3'b101;
      repeat (3) tick;
      tests++;
      if ({pwm_out, AP, AN, BP, BN, CP, CN} !== 7'b0) begin
         fails++;
         $display("FAIL reset_outputs: got %b, required 0000000", {pwm_out, AP, AN, BP, BN, CP, CN});
      end
      check_post_reset("reset");
   endtask

   task automatic test_pwm_basic;
      int fl;
      wait_period_start("basic");
      dq.push_back(124);
      measure_period("basic_7c", hall_table(3'b101), -1, 8'h00, fl);
   endtask

   task automatic test_commutation;
      logic [2:0] seq [5];
      seq = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
      for (int i = 0; i < 5; i++) hall_step(seq[i], 1000);
   endtask

   task automatic test_fault;
      hall_step(3'b111, 300);
      hall_step(3'b000, 300);
      hall_step(3'b100, 300);
      hall_step(3'b101, 300);
   endtask

   task automatic test_duty;
      pat_t g;
      int fl;
      g = hall_table(3'b101);
      wait_period_start("duty");
      dq.push_back(124);
      dq.push_back(16);
      measure_period("duty_keep_124", g, 100, 8'h10, fl);
      measure_period("duty_next_16", g, -1, 8'h00, fl);
      pwm_in = 8'h00;
      dq.push_back(16);
      dq.push_back(0);
      measure_period("duty_prev_16", g, -1, 8'h00, fl);
      measure_period("duty_zero", g, -1, 8'h00, fl);
      pwm_in = 8'hFF;
      dq.push_back(0);
      dq.push_back(255);
      measure_period("duty_prev_zero", g, -1, 8'h00, fl);
      measure_period("duty_ff", g, -1, 8'h00, fl);
      pwm_in = 8'h7C;
      dq.push_back(255);
      dq.push_back(124);
      measure_period("duty_prev_ff", g, -1, 8'h00, fl);
      measure_period("duty_back_7c", g, -1, 8'h00, fl);
   endtask

   task automatic test_enable;
      int bad = 0;
      int fl;
      repeat (37) tick;
      pwm_en = 1'b0;
      #1;
      tests++;
      if ({AP, AN, BP, BN, CP, CN} !== 6'b0) begin
         fails++;
         $display("FAIL enable_off_now: gates %b, required 000000", {AP, AN, BP, BN, CP, CN});
      end
      for (int k = 0; k < 300; k++) begin
         tick;
         if ({pwm_out, AP, AN, BP, BN, CP, CN} !== 7'b0) bad++;
         if (k == 100) begin
            {H1, H2, H3} = 3'b100;
            cur_h = 3'b100;
         end
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL enable_off_hold: %0d active cycles, required 0", bad);
      end
      wait_period_start("enable");
      pwm_en = 1'b1;
      #1;
      tests++;
      if ({CN, BN, AN} !== 3'b100 || {CP, BP, AP} !== 3'b000) begin
         fails++;
         $display("FAIL enable_resume_now: P=%b N=%b, required P=000 N=100", {CP, BP, AP}, {CN, BN, AN});
      end
      dq.push_back(124);
      measure_period("enable_resume", hall_table(3'b100), -1, 8'h00, fl);
      tests++;
      if (fl != 124) begin
         fails++;
         $display("FAIL enable_phase: first low clock %0d, required 124", fl);
      end
      hall_step(3'b101, 300);
   endtask

   task automatic test_glitch_reset;
      pat_t g, e;
      int cn_seen = 0;
      int n = 0;
      int fl;
      g = hall_table(3'b101);
      for (int j = 1; j <= 6; j++) begin
         e = '0;
         if (j <= 2) e = g;
         gq.push_back(e);
      end
      {H1, H2, H3} = 3'b100;
      for (int j = 1; j <= 6; j++) begin
         tick;
         if (j == 4) {H1, H2, H3} = 3'b101;
         e = gq.pop_front();
         tests++;
         if ({CN, BN, AN} !== e.lo || {CP, BP, AP} !== (e.hi & {3{pwm_out}})) begin
            fails++;
            $display("FAIL glitch cycle %0d: P=%b N=%b, required P=%b N=%b",
                     j, {CP, BP, AP}, {CN, BN, AN}, e.hi & {3{pwm_out}}, e.lo);
         end
      end
      for (int k = 0; k < 20; k++) begin
         tick;
         if (CN === 1'b1) cn_seen++;
      end
      tests++;
      if (cn_seen != 0 || {CN, BN, AN} !== g.lo) begin
         fails++;
         $display("FAIL glitch_settle: CN high %0d cycles, N=%b, required 0 and %b", cn_seen, {CN, BN, AN}, g.lo);
      end
      while ((ecount % PERIOD) != 100 && n < 2 * PERIOD) begin
         tick;
         n++;
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({pwm_out, AP, AN, BP, BN, CP, CN} !== 7'b0) begin
         fails++;
         $display("FAIL reset_async: got %b, required 0000000", {pwm_out, AP, AN, BP, BN, CP, CN});
      end
      @(negedge clk);
      repeat (2) tick;
      tests++;
      if ({pwm_out, AP, AN, BP, BN, CP, CN} !== 7'b0) begin
         fails++;
         $display("FAIL reset_held: got %b, required 0000000", {pwm_out, AP, AN, BP, BN, CP, CN});
      end
      check_post_reset("midreset");
      dq.push_back(124);
      measure_period("midreset_pwm", g, -1, 8'h00, fl);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset;
      test_pwm_basic;
      test_commutation;
      test_fault;
      test_duty;
      test_enable;
      test_glitch_reset;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
